// File: rtl/tb_run_ctrl_pkg.sv
// Shared types for the run controller: FSM state, verdict record, "no failing channel" index.
package tb_run_ctrl_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic done;
    logic pass;
    logic timeout;
  } verdict_t;

  // Wide enough for the largest index port (NUM_CH up to 16); callers slice it down.
  localparam logic [4:0] FAIL_NONE = 5'h1f;

endpackage

// File: rtl/tb_exit_latch.sv
// Per-channel sticky exit flag with first-value-wins capture of the exit value.
module tb_exit_latch #(
  parameter int EXIT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              strobe,
  input  logic [EXIT_W-1:0] value,
  output logic              exited,
  output logic [EXIT_W-1:0] captured
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exited   <= 1'b0;
      captured <= '0;
    end else if (enable && strobe && !exited) begin
      exited   <= 1'b1;
      captured <= value;
    end
  end

endmodule

// File: rtl/tb_run_ctrl.sv
// Run controller: reset/fetch sequencing, cycle limit, exit collection, pass/fail/timeout verdict.
// Optional heartbeat pulse is built only when TB_RUN_CTRL_HEARTBEAT_EN is defined.
module tb_run_ctrl
  import tb_run_ctrl_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int RST_WAIT = 4,
  parameter int CNT_W    = 32,
  parameter int EXIT_W   = 32,
  parameter int ALL_EXIT = 1,
  parameter int HB_LOG2  = 20
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [CNT_W-1:0]           max_cycles_i,
  input  logic [NUM_CH-1:0]          exit_valid_i,
  input  logic [NUM_CH*EXIT_W-1:0]   exit_value_i,
  output logic                       core_rst_no,
  output logic                       fetch_enable_o,
  output logic [CNT_W-1:0]           cycle_cnt_o,
  output logic [NUM_CH-1:0]          exited_o,
  output logic                       done_o,
  output logic                       pass_o,
  output logic                       timeout_o,
  output logic [$clog2(NUM_CH):0]    fail_idx_o,
  output logic [EXIT_W-1:0]          fail_value_o,
  output logic                       heartbeat_o
);

  localparam int IDX_W  = $clog2(NUM_CH) + 1;
  localparam int WAIT_W = (RST_WAIT > 1) ? $clog2(RST_WAIT) : 1;

  state_t              state;
  verdict_t            verdict;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [NUM_CH-1:0]   exited;
  logic [NUM_CH-1:0]   exited_next;
  logic [NUM_CH-1:0]   nonzero;
  logic [EXIT_W-1:0]   captured [NUM_CH];
  logic                cap_en;
  logic                timeout_hit;

  function automatic logic done_met(input logic [NUM_CH-1:0] flags);
    return (ALL_EXIT != 0) ? &flags : |flags;
  endfunction

  // Captures stop once the done condition holds so the verdict edge sees a frozen set.
  assign cap_en      = (state == RUN) && !done_met(exited);
  assign exited_next = exited | (exit_valid_i & {NUM_CH{cap_en}});

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      tb_exit_latch #(.EXIT_W(EXIT_W)) u_latch (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .enable   (cap_en),
        .strobe   (exit_valid_i[gi]),
        .value    (exit_value_i[gi*EXIT_W +: EXIT_W]),
        .exited   (exited[gi]),
        .captured (captured[gi])
      );
      assign nonzero[gi] = |captured[gi];
    end
  endgenerate

  // An exit landing this cycle that completes the set outranks the cycle limit.
  assign timeout_hit = (max_cycles_i != '0) && (cycle_cnt_o >= max_cycles_i) &&
                       !done_met(exited_next);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state          <= WAIT;
      wait_cnt       <= '0;
      cycle_cnt_o    <= '0;
      verdict        <= '0;
      core_rst_no    <= 1'b0;
      fetch_enable_o <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          if (wait_cnt == WAIT_W'(RST_WAIT - 1)) begin
            state          <= RUN;
            core_rst_no    <= 1'b1;
            fetch_enable_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RUN: begin
          if (done_met(exited)) begin
            state          <= DONE;
            fetch_enable_o <= 1'b0;
            verdict        <= '{done: 1'b1, pass: ~|nonzero, timeout: 1'b0};
          end else if (timeout_hit) begin
            state          <= DONE;
            fetch_enable_o <= 1'b0;
            verdict        <= '{done: 1'b1, pass: 1'b0, timeout: 1'b1};
          end else if (cycle_cnt_o != '1) begin
            cycle_cnt_o <= cycle_cnt_o + 1'b1;
          end
        end
        DONE: ;
        default: state <= WAIT;
      endcase
    end
  end

  // Lowest nonzero channel wins; latches are frozen outside RUN, so the report is too.
  always_comb begin
    fail_idx_o   = FAIL_NONE[IDX_W-1:0];
    fail_value_o = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (nonzero[k]) begin
        fail_idx_o   = IDX_W'(k);
        fail_value_o = captured[k];
      end
    end
  end

  assign exited_o  = exited;
  assign done_o    = verdict.done;
  assign pass_o    = verdict.pass;
  assign timeout_o = verdict.timeout;

`ifdef TB_RUN_CTRL_HEARTBEAT_EN
  assign heartbeat_o = (state == RUN) && (cycle_cnt_o[HB_LOG2-1:0] == '0) &&
                       (cycle_cnt_o != '0);
`else
  assign heartbeat_o = 1'b0;
`endif

endmodule

// File: tb/tb_tb_run_ctrl.sv
// Directed bench for tb_run_ctrl: table of per-cycle vectors plus hand sequences
// for fail priority, timeout, exit/timeout tie, ANY mode and heartbeat.
module tb_tb_run_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // ALL-exit instance
  logic        rst_a, core_a, fetch_a, done_a, pass_a, tmo_a, hb_a;
  logic [31:0] max_a, cnt_a, fval_a;
  logic [1:0]  valid_a, ex_a, fidx_a;
  logic [63:0] value_a;

  // ANY-exit instance with a short heartbeat period
  logic        rst_b, core_b, fetch_b, done_b, pass_b, tmo_b, hb_b;
  logic [31:0] max_b, cnt_b, fval_b;
  logic [1:0]  valid_b, ex_b, fidx_b;
  logic [63:0] value_b;

  tb_run_ctrl #(.NUM_CH(2), .RST_WAIT(4), .CNT_W(32), .EXIT_W(32), .ALL_EXIT(1), .HB_LOG2(20)) dut_a (
    .clk_i(clk), .rst_ni(rst_a), .max_cycles_i(max_a), .exit_valid_i(valid_a),
    .exit_value_i(value_a), .core_rst_no(core_a), .fetch_enable_o(fetch_a),
    .cycle_cnt_o(cnt_a), .exited_o(ex_a), .done_o(done_a), .pass_o(pass_a),
    .timeout_o(tmo_a), .fail_idx_o(fidx_a), .fail_value_o(fval_a), .heartbeat_o(hb_a)
  );

  tb_run_ctrl #(.NUM_CH(2), .RST_WAIT(4), .CNT_W(32), .EXIT_W(32), .ALL_EXIT(0), .HB_LOG2(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_b), .max_cycles_i(max_b), .exit_valid_i(valid_b),
    .exit_value_i(value_b), .core_rst_no(core_b), .fetch_enable_o(fetch_b),
    .cycle_cnt_o(cnt_b), .exited_o(ex_b), .done_o(done_b), .pass_o(pass_b),
    .timeout_o(tmo_b), .fail_idx_o(fidx_b), .fail_value_o(fval_b), .heartbeat_o(hb_b)
  );

  typedef struct {
    int          pre;
    logic        rst_n;
    logic [1:0]  valid;
    logic [31:0] v0;
    logic [31:0] v1;
    logic        core;
    logic        fetch;
    logic [1:0]  ex;
    logic        done;
    logic        pass;
    logic [1:0]  fidx;
    logic [31:0] fval;
    logic [31:0] cnt;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_a();
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    int guard;
    int hb_count;
    logic [31:0] hb_at;

    rst_a = 1'b0; max_a = '0; valid_a = '0; value_a = '0;
    rst_b = 1'b0; max_b = '0; valid_b = '0; value_b = '0;

    //          pre rst valid v0 v1   core fetch ex    done pass fidx  fval cnt
    vecs[0]  = '{0,  0, 2'b00, 0, 0,   0, 0, 2'b00, 0, 0, 2'b11, 0, 0};
    vecs[1]  = '{0,  1, 2'b11, 9, 9,   0, 0, 2'b00, 0, 0, 2'b11, 0, 0};
    vecs[2]  = '{1,  1, 2'b00, 0, 0,   0, 0, 2'b00, 0, 0, 2'b11, 0, 0};
    vecs[3]  = '{0,  1, 2'b00, 0, 0,   1, 1, 2'b00, 0, 0, 2'b11, 0, 0};
    vecs[4]  = '{10, 1, 2'b01, 0, 0,   1, 1, 2'b01, 0, 0, 2'b11, 0, 11};
    vecs[5]  = '{0,  1, 2'b01, 7, 0,   1, 1, 2'b01, 0, 0, 2'b11, 0, 12};
    vecs[6]  = '{8,  1, 2'b10, 0, 0,   1, 1, 2'b11, 0, 0, 2'b11, 0, 21};
    vecs[7]  = '{0,  1, 2'b00, 0, 0,   1, 0, 2'b11, 1, 1, 2'b11, 0, 21};
    vecs[8]  = '{3,  1, 2'b01, 7, 0,   1, 0, 2'b11, 1, 1, 2'b11, 0, 21};
    vecs[9]  = '{0,  0, 2'b00, 0, 0,   0, 0, 2'b00, 0, 0, 2'b11, 0, 0};
    vecs[10] = '{2,  1, 2'b00, 0, 0,   0, 0, 2'b00, 0, 0, 2'b11, 0, 0};
    vecs[11] = '{0,  1, 2'b00, 0, 0,   1, 1, 2'b00, 0, 0, 2'b11, 0, 0};
    vecs[12] = '{5,  1, 2'b10, 0, 0,   1, 1, 2'b10, 0, 0, 2'b11, 0, 6};
    vecs[13] = '{0,  0, 2'b00, 0, 0,   0, 0, 2'b00, 0, 0, 2'b11, 0, 0};
    vecs[14] = '{2,  1, 2'b00, 0, 0,   0, 0, 2'b00, 0, 0, 2'b11, 0, 0};
    vecs[15] = '{0,  1, 2'b00, 0, 0,   1, 1, 2'b00, 0, 0, 2'b11, 0, 0};

    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      for (int p = 0; p < vecs[i].pre; p++) begin
        rst_a = 1'b1; valid_a = '0;
        tick();
      end
      rst_a   = vecs[i].rst_n;
      valid_a = vecs[i].valid;
      value_a = {vecs[i].v1, vecs[i].v0};
      tick();
      valid_a = '0;
      $display("vec %0d: core=%b fetch=%b ex=%b done=%b pass=%b fidx=%0d cnt=%0d",
               i, core_a, fetch_a, ex_a, done_a, pass_a, fidx_a, cnt_a);
      chk($sformatf("vec%0d core_rst", i), 64'(core_a), 64'(vecs[i].core));
      chk($sformatf("vec%0d fetch", i),    64'(fetch_a), 64'(vecs[i].fetch));
      chk($sformatf("vec%0d exited", i),   64'(ex_a), 64'(vecs[i].ex));
      chk($sformatf("vec%0d done", i),     64'(done_a), 64'(vecs[i].done));
      chk($sformatf("vec%0d pass", i),     64'(pass_a), 64'(vecs[i].pass));
      chk($sformatf("vec%0d timeout", i),  64'(tmo_a), 64'(0));
      chk($sformatf("vec%0d fail_idx", i), 64'(fidx_a), 64'(vecs[i].fidx));
      chk($sformatf("vec%0d fail_val", i), 64'(fval_a), 64'(vecs[i].fval));
      chk($sformatf("vec%0d cycle_cnt", i), 64'(cnt_a), 64'(vecs[i].cnt));
    end

    // Simultaneous fails: lower channel reported.
    release_a();
    repeat (3) tick();
    valid_a = 2'b11; value_a = {32'd5, 32'd3};
    tick();
    valid_a = '0;
    $display("simul: ex=%b fidx=%0d fval=%0d", ex_a, fidx_a, fval_a);
    chk("simul exited", 64'(ex_a), 64'(2'b11));
    chk("simul fail_idx", 64'(fidx_a), 64'(0));
    chk("simul fail_val", 64'(fval_a), 64'(3));
    chk("simul done_early", 64'(done_a), 64'(0));
    tick();
    $display("simul verdict: done=%b pass=%b timeout=%b", done_a, pass_a, tmo_a);
    chk("simul done", 64'(done_a), 64'(1));
    chk("simul pass", 64'(pass_a), 64'(0));
    chk("simul timeout", 64'(tmo_a), 64'(0));

    // Timeout at 100 cycles, counter frozen afterwards.
    max_a = 32'd100;
    release_a();
    guard = 0;
    while (!done_a && guard < 200) begin
      tick();
      guard++;
    end
    $display("timeout: done=%b timeout=%b cnt=%0d after %0d cycles", done_a, tmo_a, cnt_a, guard);
    chk("timeout reached", 64'(done_a), 64'(1));
    chk("timeout flag", 64'(tmo_a), 64'(1));
    chk("timeout pass", 64'(pass_a), 64'(0));
    chk("timeout cnt", 64'(cnt_a), 64'(100));
    chk("timeout fetch", 64'(fetch_a), 64'(0));
    repeat (5) tick();
    chk("timeout cnt frozen", 64'(cnt_a), 64'(100));

    // Last channel exits on the cycle the count reaches the limit: exit wins.
    max_a = 32'd50;
    release_a();
    repeat (5) tick();
    valid_a = 2'b01; value_a = '0;
    tick();
    valid_a = '0;
    guard = 0;
    while (cnt_a != 32'd50 && guard < 100) begin
      tick();
      guard++;
    end
    chk("tie reach limit", 64'(cnt_a), 64'(50));
    valid_a = 2'b10; value_a = '0;
    tick();
    valid_a = '0;
    chk("tie exited", 64'(ex_a), 64'(2'b11));
    chk("tie no early timeout", 64'(done_a), 64'(0));
    tick();
    $display("tie: done=%b pass=%b timeout=%b", done_a, pass_a, tmo_a);
    chk("tie done", 64'(done_a), 64'(1));
    chk("tie pass", 64'(pass_a), 64'(1));
    chk("tie timeout", 64'(tmo_a), 64'(0));
    max_a = '0;

    // ANY mode plus heartbeat on the second instance.
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    repeat (4) tick();
    chk("any core_rst", 64'(core_b), 64'(1));
    hb_count = 0;
    hb_at    = '0;
    for (int c = 0; c < 20; c++) begin
      if (hb_b) begin
        hb_count++;
        hb_at = cnt_b;
      end
      tick();
    end
    $display("heartbeat: pulses=%0d at cnt=%0d", hb_count, hb_at);
`ifdef TB_RUN_CTRL_HEARTBEAT_EN
    chk("hb pulses", 64'(hb_count), 64'(1));
    chk("hb position", 64'(hb_at), 64'(16));
`else
    chk("hb pulses", 64'(hb_count), 64'(0));
`endif
    valid_b = 2'b10; value_b = '0;
    tick();
    valid_b = '0;
    chk("any exited", 64'(ex_b), 64'(2'b10));
    chk("any done_early", 64'(done_b), 64'(0));
    tick();
    $display("any: done=%b pass=%b ex=%b fidx=%0d", done_b, pass_b, ex_b, fidx_b);
    chk("any done", 64'(done_b), 64'(1));
    chk("any pass", 64'(pass_b), 64'(1));
    chk("any exited_final", 64'(ex_b), 64'(2'b10));
    chk("any fail_idx", 64'(fidx_b), 64'(2'b11));
    chk("any timeout", 64'(tmo_b), 64'(0));
    chk("any fetch", 64'(fetch_b), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
